// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sar_pkg
// Brief   : Shared state encodings and flag helper for the SAR search block.
// Rev     : 1.0  initial release
// ============================================================================
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } sar_state_e;

  // True when exactly one of the comparator flags is asserted.
  function automatic logic onehot3(input logic g, input logic e, input logic l);
    return (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
// Module  : sar_search
// Brief   : Successive-approximation controller. Presents a trial code to an
//           external magnitude comparator and binary-searches the target
//           from the returned greater/equal/less flags.
// Config  : SAR_EARLY_EXIT_EN - when defined, an "equal" flag ends the
//           search at once with the current trial as the result.
// Rev     : 1.0  initial release
// ============================================================================
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_l,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_e       state_q;
  logic [WIDTH-1:0] trial_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] resolved;
  logic [WIDTH-1:0] trial_d;
  logic             flags_ok;

  // Resolve the bit under test and pre-set the next lower bit for the next trial.
  always_comb begin
    bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
    resolved = cmp_g ? (trial_q & ~bit_mask) : trial_q;
    trial_d  = resolved | (bit_mask >> 1);
    flags_ok = onehot3(cmp_g, cmp_e, cmp_l);
  end

  // Search FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      trial_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            trial_q <= {1'b1, {(WIDTH-1){1'b0}}};
            idx_q   <= IW'(WIDTH - 1);
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (!flags_ok) begin
            // Broken comparator: report the trial that exposed it.
            err_q    <= 1'b1;
            result_q <= trial_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
`ifdef SAR_EARLY_EXIT_EN
          else if (cmp_e) begin
            // Exact hit: lower bits are still 0, so the trial is the answer.
            result_q <= trial_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
`endif
          else if (idx_q == '0) begin
            trial_q  <= resolved;
            result_q <= resolved;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            trial_q <= trial_d;
            idx_q   <= idx_q - IW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ============================================================================
// Module  : tb_sar_search
// Brief   : Directed bench for sar_search (WIDTH=4) with a behavioural
//           comparator closing the loop. Honours SAR_EARLY_EXIT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmp_g;
  logic       cmp_e;
  logic       cmp_l;
  logic [3:0] trial;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  logic [3:0] target;
  logic       force_gl;

  int n_checks;
  int n_errors;

  logic [3:0] tr [16];
  int         ntr;

  sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_g  (cmp_g),
    .cmp_e  (cmp_e),
    .cmp_l  (cmp_l),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator; force_gl injects an illegal g=l=1 response.
  assign cmp_g = force_gl | (trial > target);
  assign cmp_l = force_gl | (trial < target);
  assign cmp_e = ~force_gl & (trial == target);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Run one search: etr packs expected trials, first trial in bits [15:12].
  task automatic do_search(input string tag, input logic [3:0] tgt, input logic [3:0] eres,
                           input int elat, input bit eerr, input logic [15:0] etr,
                           input int entr, input int bad_idx, input bit poke);
    int cnt;
    logic [15:0] etr_v;
    etr_v  = etr;
    target = tgt;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    ntr = 0;
    while (!done && cnt < 20) begin
      if (busy) begin
        if (ntr < 16) tr[ntr] = trial;
        ntr++;
      end
      force_gl = (cnt == bad_idx);
      if (poke) start = (cnt == 1);
      @(posedge clk); #1;
      cnt++;
    end
    force_gl = 1'b0;
    start    = 1'b0;
    check_eq({tag, " latency"}, cnt, elat);
    check_eq({tag, " done"}, done, 1'b1);
    check_eq({tag, " busy at done"}, busy, 1'b0);
    check_eq({tag, " result"}, result, eres);
    check_eq({tag, " err"}, err, eerr);
    check_eq({tag, " trial count"}, ntr, entr);
    for (int i = 0; i < entr; i++)
      check_eq($sformatf("%s trial%0d", tag, i), tr[i], etr_v[15-4*i -: 4]);
    @(posedge clk); #1;
    check_eq({tag, " done pulse width"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    target   = 4'd0;
    force_gl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset trial",  trial,  4'd0);
    check_eq("reset busy",   busy,   1'b0);
    check_eq("reset done",   done,   1'b0);
    check_eq("reset result", result, 4'd0);
    check_eq("reset err",    err,    1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_search("t11", 4'd11, 4'd11, 4, 1'b0, {4'd8, 4'd12, 4'd10, 4'd11}, 4, -1, 1'b0);
    do_search("t0",  4'd0,  4'd0,  4, 1'b0, {4'd8, 4'd4,  4'd2,  4'd1},  4, -1, 1'b0);
    do_search("t15", 4'd15, 4'd15, 4, 1'b0, {4'd8, 4'd12, 4'd14, 4'd15}, 4, -1, 1'b0);
`ifdef SAR_EARLY_EXIT_EN
    do_search("t8",  4'd8,  4'd8,  1, 1'b0, {4'd8, 12'd0}, 1, -1, 1'b0);
`else
    do_search("t8",  4'd8,  4'd8,  4, 1'b0, {4'd8, 4'd12, 4'd10, 4'd9},  4, -1, 1'b0);
`endif
    do_search("bad", 4'd11, 4'd12, 2, 1'b1, {4'd8, 4'd12, 8'd0}, 2, 1, 1'b0);

    // Abort a search with reset in its third cycle.
    target = 4'd5;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort trial",  trial,  4'd0);
    check_eq("abort busy",   busy,   1'b0);
    check_eq("abort done",   done,   1'b0);
    check_eq("abort result", result, 4'd0);
    check_eq("abort err",    err,    1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post-abort idle busy", busy, 1'b0);

    // Extra start pulse while busy must be ignored.
    do_search("t5 poke", 4'd5, 4'd5, 4, 1'b0, {4'd8, 4'd4, 4'd6, 4'd5}, 4, -1, 1'b1);
    @(posedge clk); #1;
    check_eq("no queued search", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
